// File: rtl/fib_pkg.sv
// Shared types and defaults for the Fibonacci range sweeper.
package fib_pkg;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_CLEAR,
    ST_WAIT_DONE,
    ST_EMIT,
    ST_FINISH
  } sweep_state_t;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fib_sweeper_if.sv
// Calculator initiator port plus result stream of the sweeper, bundled as one interface.
interface fib_sweeper_if #(
  parameter int unsigned INPUT_WIDTH  = 6,
  parameter int unsigned OUTPUT_WIDTH = 32
);

  logic                    fib_go;
  logic [INPUT_WIDTH-1:0]  fib_n;
  logic [OUTPUT_WIDTH-1:0] fib_result;
  logic                    fib_overflow;
  logic                    fib_done;

  logic                    out_valid;
  logic                    out_ready;
  logic [INPUT_WIDTH-1:0]  out_n;
  logic [OUTPUT_WIDTH-1:0] out_result;
  logic                    out_overflow;
  logic                    out_last;

  modport master (
    output fib_go, fib_n, out_valid, out_n, out_result, out_overflow, out_last,
    input  fib_result, fib_overflow, fib_done, out_ready
  );

  modport slave (
    input  fib_go, fib_n, out_valid, out_n, out_result, out_overflow, out_last,
    output fib_result, fib_overflow, fib_done, out_ready
  );

endinterface

// File: rtl/fib.sv
// Iterative Fibonacci calculator; done stays high after a result until the next go.
module fib #(
  parameter int unsigned INPUT_WIDTH  = 6,
  parameter int unsigned OUTPUT_WIDTH = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_go,
  input  logic [INPUT_WIDTH-1:0]  i_n,
  output logic [OUTPUT_WIDTH-1:0] o_result,
  output logic                    o_overflow,
  output logic                    o_done
);

  logic [INPUT_WIDTH-1:0]  r_cnt;
  logic [OUTPUT_WIDTH-1:0] r_a;
  logic [OUTPUT_WIDTH-1:0] r_b;
  logic                    r_a_ovf;
  logic                    r_b_ovf;
  logic                    r_busy;
  logic                    r_done;
  logic [OUTPUT_WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  // Overflow flags travel with each term so the wrapped value is still marked.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (i_go) begin
      r_cnt   <= i_n;
      r_a     <= '0;
      r_b     <= OUTPUT_WIDTH'(1);
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
      r_busy  <= 1'b1;
      r_done  <= 1'b0;
    end else if (r_busy) begin
      if (r_cnt == '0) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_cnt   <= r_cnt - INPUT_WIDTH'(1);
        r_a     <= r_b;
        r_a_ovf <= r_b_ovf;
        r_b     <= w_sum[OUTPUT_WIDTH-1:0];
        r_b_ovf <= r_a_ovf | r_b_ovf | w_sum[OUTPUT_WIDTH];
      end
    end
  end

  assign o_result   = r_a;
  assign o_overflow = r_a_ovf;
  assign o_done     = r_done;

endmodule

// File: rtl/fib_wait_timer.sv
// Per-request wait budget: down-counter loaded on clear, expired at terminal count while enabled.
module fib_wait_timer
  import fib_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= CW'(TIMEOUT_CYCLES);
    end else if (i_enable && (r_count != '0)) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_expired = i_enable && (r_count == '0);

endmodule

// File: rtl/fib_sweeper.sv
// Walks n over an inclusive range, asks an external calculator for F(n), streams each result.
//   state      | meaning
//   IDLE       | waiting for start; range latched on accept
//   ISSUE      | one-cycle fib_go for cur_n
//   WAIT_CLEAR | wait for the previous fib_done to drop
//   WAIT_DONE  | wait for fib_done, capture result/overflow
//   EMIT       | hold out_valid until out_ready
//   FINISH     | one-cycle done pulse
module fib_sweeper
  import fib_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH    = 6,
  parameter int unsigned OUTPUT_WIDTH   = 32,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic [INPUT_WIDTH-1:0] i_n_first,
  input  logic [INPUT_WIDTH-1:0] i_n_last,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_timeout,
  output logic                   o_sweep_overflow,
  fib_sweeper_if.master          bus
);

  sweep_state_t            r_state;
  sweep_state_t            w_state_nxt;
  logic [INPUT_WIDTH-1:0]  r_cur_n;
  logic [INPUT_WIDTH-1:0]  r_n_last;
  logic [OUTPUT_WIDTH-1:0] r_out_result;
  logic                    r_out_overflow;
  logic                    r_timeout;
  logic                    r_sweep_ovf;

  logic w_accept;
  logic w_capture;
  logic w_advance;
  logic w_expire;
  logic w_last;
  logic w_timer_clr;
  logic w_timer_en;
  logic w_expired;

  assign w_last      = (r_cur_n == r_n_last);
  assign w_timer_clr = (r_state == ST_ISSUE);
  assign w_timer_en  = (r_state == ST_WAIT_CLEAR) || (r_state == ST_WAIT_DONE);

  fib_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_capture     = 1'b0;
    w_advance     = 1'b0;
    w_expire      = 1'b0;
    o_busy        = (r_state != ST_IDLE);
    o_done        = 1'b0;
    bus.fib_go    = 1'b0;
    bus.out_valid = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = (i_n_first <= i_n_last) ? ST_ISSUE : ST_FINISH;
        end
      end
      ST_ISSUE: begin
        bus.fib_go  = 1'b1;
        w_state_nxt = ST_WAIT_CLEAR;
      end
      ST_WAIT_CLEAR: begin
        if (w_expired) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_FINISH;
        end else if (!bus.fib_done) begin
          w_state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // A result arriving on the last budgeted cycle still counts.
        if (bus.fib_done) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_EMIT;
        end else if (w_expired) begin
          w_expire    = 1'b1;
          w_state_nxt = ST_FINISH;
        end
      end
      ST_EMIT: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) begin
          if (w_last) begin
            w_state_nxt = ST_FINISH;
          end else begin
            w_advance   = 1'b1;
            w_state_nxt = ST_ISSUE;
          end
        end
      end
      ST_FINISH: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cur_n        <= '0;
      r_n_last       <= '0;
      r_out_result   <= '0;
      r_out_overflow <= 1'b0;
      r_timeout      <= 1'b0;
      r_sweep_ovf    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_n     <= i_n_first;
        r_n_last    <= i_n_last;
        r_timeout   <= 1'b0;
        r_sweep_ovf <= 1'b0;
      end
      if (w_advance) begin
        r_cur_n <= r_cur_n + INPUT_WIDTH'(1);
      end
      if (w_capture) begin
        r_out_result   <= bus.fib_result;
        r_out_overflow <= bus.fib_overflow;
        r_sweep_ovf    <= r_sweep_ovf | bus.fib_overflow;
      end
      if (w_expire) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_timeout        = r_timeout;
  assign o_sweep_overflow = r_sweep_ovf;
  assign bus.fib_n        = r_cur_n;
  assign bus.out_n        = r_cur_n;
  assign bus.out_result   = r_out_result;
  assign bus.out_overflow = r_out_overflow;
  assign bus.out_last     = bus.out_valid && w_last;

endmodule

// File: tb/tb_fib_sweeper.sv
// Scoreboard bench for fib_sweeper: 32-bit, 8-bit and short-timeout instances on one clock.
module tb_fib_sweeper;

  typedef struct packed {
    logic [5:0]  n;
    logic [31:0] res;
    logic        ovf;
    logic        last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic       start_c = 1'b0;
  logic [5:0] n_first = '0;
  logic [5:0] n_last = '0;

  logic a_busy, a_done, a_tmo, a_sovf;
  logic b_busy, b_done, b_tmo, b_sovf;
  logic c_busy, c_done, c_tmo, c_sovf;

  int n_checks = 0;
  int n_pass   = 0;
  int beats_a  = 0;
  int beats_b  = 0;
  int done_a   = 0;
  int valid_c  = 0;

  beat_t q_a[$];
  beat_t q_b[$];

  always #5 clk = ~clk;

  fib_sweeper_if #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32)) bus_a ();
  fib_sweeper_if #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(8))  bus_b ();
  fib_sweeper_if #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32)) bus_c ();

  fib_sweeper #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32), .TIMEOUT_CYCLES(1024)) u_dut_a (
    .i_clk(clk), .i_rst(rst), .i_start(start_a), .i_n_first(n_first), .i_n_last(n_last),
    .o_busy(a_busy), .o_done(a_done), .o_timeout(a_tmo), .o_sweep_overflow(a_sovf), .bus(bus_a)
  );
  fib_sweeper #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(8), .TIMEOUT_CYCLES(1024)) u_dut_b (
    .i_clk(clk), .i_rst(rst), .i_start(start_b), .i_n_first(n_first), .i_n_last(n_last),
    .o_busy(b_busy), .o_done(b_done), .o_timeout(b_tmo), .o_sweep_overflow(b_sovf), .bus(bus_b)
  );
  fib_sweeper #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32), .TIMEOUT_CYCLES(16)) u_dut_c (
    .i_clk(clk), .i_rst(rst), .i_start(start_c), .i_n_first(n_first), .i_n_last(n_last),
    .o_busy(c_busy), .o_done(c_done), .o_timeout(c_tmo), .o_sweep_overflow(c_sovf), .bus(bus_c)
  );

  fib #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(32)) u_fib_a (
    .i_clk(clk), .i_rst(rst), .i_go(bus_a.fib_go), .i_n(bus_a.fib_n),
    .o_result(bus_a.fib_result), .o_overflow(bus_a.fib_overflow), .o_done(bus_a.fib_done)
  );
  fib #(.INPUT_WIDTH(6), .OUTPUT_WIDTH(8)) u_fib_b (
    .i_clk(clk), .i_rst(rst), .i_go(bus_b.fib_go), .i_n(bus_b.fib_n),
    .o_result(bus_b.fib_result), .o_overflow(bus_b.fib_overflow), .o_done(bus_b.fib_done)
  );

  // Stub responder that never answers.
  assign bus_c.fib_result   = '0;
  assign bus_c.fib_overflow = 1'b0;
  assign bus_c.fib_done     = 1'b0;
  assign bus_c.out_ready    = 1'b1;
  assign bus_b.out_ready    = 1'b1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic beat_t mk_beat(input int n, input int last_n, input int width);
    beat_t       b;
    logic [63:0] x = 64'd0;
    logic [63:0] y = 64'd1;
    logic [63:0] t;
    logic [63:0] mask;
    for (int i = 0; i < n; i++) begin
      t = x + y;
      x = y;
      y = t;
    end
    mask   = (64'd1 << width) - 64'd1;
    b.n    = 6'(n);
    b.res  = 32'(x & mask);
    b.ovf  = (x > mask);
    b.last = (n == last_n);
    return b;
  endfunction

  task automatic observe();
    beat_t e;
    if (rst) return;
    if (bus_a.out_valid && bus_a.out_ready) begin
      beats_a++;
      check_val("a_beat_expected", 64'(q_a.size() > 0), 64'd1);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        check_val($sformatf("a_out_n@%0d", e.n), 64'(bus_a.out_n), 64'(e.n));
        check_val($sformatf("a_result@%0d", e.n), 64'(bus_a.out_result), 64'(e.res));
        check_val($sformatf("a_ovf@%0d", e.n), 64'(bus_a.out_overflow), 64'(e.ovf));
        check_val($sformatf("a_last@%0d", e.n), 64'(bus_a.out_last), 64'(e.last));
      end
    end
    if (bus_b.out_valid && bus_b.out_ready) begin
      beats_b++;
      check_val("b_beat_expected", 64'(q_b.size() > 0), 64'd1);
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        check_val($sformatf("b_out_n@%0d", e.n), 64'(bus_b.out_n), 64'(e.n));
        check_val($sformatf("b_result@%0d", e.n), 64'(bus_b.out_result), 64'(e.res));
        check_val($sformatf("b_ovf@%0d", e.n), 64'(bus_b.out_overflow), 64'(e.ovf));
        check_val($sformatf("b_last@%0d", e.n), 64'(bus_b.out_last), 64'(e.last));
      end
    end
    if (a_done) done_a++;
    if (bus_c.out_valid) valid_c++;
  endtask

  // Outputs sampled on the falling edge; inputs driven 1 time unit after the rising edge.
  task automatic tick();
    @(negedge clk);
    observe();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input int which, input logic [5:0] first, input logic [5:0] last);
    n_first = first;
    n_last  = last;
    case (which)
      0:       start_a = 1'b1;
      1:       start_b = 1'b1;
      default: start_c = 1'b1;
    endcase
    tick();
    start_a = 1'b0;
    start_b = 1'b0;
    start_c = 1'b0;
  endtask

  task automatic wait_done(input int which, input int limit, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      case (which)
        0:       seen = a_done;
        1:       seen = b_done;
        default: seen = c_done;
      endcase
      if (!seen) begin
        tick();
        cycles++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int cyc;
    bit seen;
    bit ok;
    int b0;
    int d0;

    bus_a.out_ready = 1'b1;
    repeat (3) tick();
    check_val("reset_outputs", 64'({a_busy, a_done, a_tmo, a_sovf, bus_a.fib_go, bus_a.fib_n,
              bus_a.out_valid, bus_a.out_n, bus_a.out_result, bus_a.out_overflow,
              bus_a.out_last}), 64'd0);
    rst = 1'b0;
    tick();

    // Range 0..10, always ready.
    for (int n = 0; n <= 10; n++) q_a.push_back(mk_beat(n, 10, 32));
    b0 = beats_a;
    d0 = done_a;
    start_sweep(0, 6'd0, 6'd10);
    wait_done(0, 2000, cyc, seen);
    check_val("range_done_seen", 64'(seen), 64'd1);
    tick();
    check_val("range_busy_after_done", 64'(a_busy), 64'd0);
    tick();
    check_val("range_beats", 64'(beats_a - b0), 64'd11);
    check_val("range_done_pulses", 64'(done_a - d0), 64'd1);
    check_val("range_queue_drained", 64'(q_a.size()), 64'd0);
    check_val("range_no_overflow", 64'(a_sovf), 64'd0);

    // Top of the n range: must stop after 63 without wrapping.
    q_a.push_back(mk_beat(62, 63, 32));
    q_a.push_back(mk_beat(63, 63, 32));
    b0 = beats_a;
    start_sweep(0, 6'd62, 6'd63);
    wait_done(0, 2000, cyc, seen);
    check_val("wrap_done_seen", 64'(seen), 64'd1);
    check_val("wrap_sweep_overflow", 64'(a_sovf), 64'd1);
    repeat (3) tick();
    check_val("wrap_beats", 64'(beats_a - b0), 64'd2);
    check_val("wrap_queue_drained", 64'(q_a.size()), 64'd0);
    check_val("wrap_idle", 64'(a_busy), 64'd0);

    // Empty range.
    b0 = beats_a;
    start_sweep(0, 6'd5, 6'd3);
    wait_done(0, 10, cyc, seen);
    check_val("empty_done_seen", 64'(seen), 64'd1);
    check_val("empty_done_within_3", 64'(cyc <= 2), 64'd1);
    check_val("empty_timeout", 64'(a_tmo), 64'd0);
    check_val("empty_sovf_cleared", 64'(a_sovf), 64'd0);
    repeat (2) tick();
    check_val("empty_no_beats", 64'(beats_a - b0), 64'd0);

    // Backpressure on n=4, with an ignored start while busy.
    for (int n = 2; n <= 6; n++) q_a.push_back(mk_beat(n, 6, 32));
    b0 = beats_a;
    start_sweep(0, 6'd2, 6'd6);
    cyc = 0;
    while (!(bus_a.fib_go && bus_a.fib_n == 6'd4) && cyc < 500) begin
      tick();
      cyc++;
    end
    check_val("bp_issue_n4", 64'(bus_a.fib_go && bus_a.fib_n == 6'd4), 64'd1);
    bus_a.out_ready = 1'b0;
    cyc = 0;
    while (!bus_a.out_valid && cyc < 500) begin
      tick();
      cyc++;
    end
    check_val("bp_valid_seen", 64'(bus_a.out_valid), 64'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ok &= bus_a.out_valid && (bus_a.out_n == 6'd4) && (bus_a.out_result == 32'd3) && !bus_a.fib_go;
      if (i == 5) begin
        n_first = 6'd0;
        n_last  = 6'd1;
        start_a = 1'b1;
      end else begin
        start_a = 1'b0;
      end
      tick();
    end
    check_val("bp_stable_20", 64'(ok), 64'd1);
    check_val("bp_hold_result", 64'(bus_a.out_result), 64'd3);
    bus_a.out_ready = 1'b1;
    wait_done(0, 2000, cyc, seen);
    check_val("bp_done_seen", 64'(seen), 64'd1);
    repeat (2) tick();
    check_val("bp_beats", 64'(beats_a - b0), 64'd5);
    check_val("bp_queue_drained", 64'(q_a.size()), 64'd0);

    // Reset while waiting on n=6.
    start_sweep(0, 6'd6, 6'd8);
    cyc = 0;
    while (!(bus_a.fib_go && bus_a.fib_n == 6'd6) && cyc < 50) begin
      tick();
      cyc++;
    end
    repeat (3) tick();
    check_val("rst_pre_waiting", 64'(a_busy && !bus_a.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    check_val("rst_mid_outputs", 64'({a_busy, a_done, a_tmo, a_sovf, bus_a.fib_go, bus_a.fib_n,
              bus_a.out_valid, bus_a.out_n, bus_a.out_result, bus_a.out_overflow,
              bus_a.out_last}), 64'd0);
    rst = 1'b0;
    tick();
    q_a.push_back(mk_beat(2, 3, 32));
    q_a.push_back(mk_beat(3, 3, 32));
    b0 = beats_a;
    start_sweep(0, 6'd2, 6'd3);
    wait_done(0, 500, cyc, seen);
    check_val("post_rst_done_seen", 64'(seen), 64'd1);
    repeat (2) tick();
    check_val("post_rst_beats", 64'(beats_a - b0), 64'd2);
    check_val("post_rst_queue_drained", 64'(q_a.size()), 64'd0);

    // 8-bit result width: 233 fits, 377 overflows.
    q_b.push_back(mk_beat(13, 14, 8));
    q_b.push_back(mk_beat(14, 14, 8));
    b0 = beats_b;
    start_sweep(1, 6'd13, 6'd14);
    wait_done(1, 500, cyc, seen);
    check_val("ovf_done_seen", 64'(seen), 64'd1);
    check_val("ovf_sweep_overflow", 64'(b_sovf), 64'd1);
    repeat (2) tick();
    check_val("ovf_beats", 64'(beats_b - b0), 64'd2);
    check_val("ovf_queue_drained", 64'(q_b.size()), 64'd0);

    // Silent responder with a 16-cycle budget.
    start_sweep(2, 6'd0, 6'd0);
    check_val("to_fib_go", 64'(bus_c.fib_go), 64'd1);
    wait_done(2, 40, cyc, seen);
    check_val("to_done_seen", 64'(seen), 64'd1);
    check_val("to_latency_window", 64'(cyc >= 16 && cyc <= 20), 64'd1);
    check_val("to_flag_at_done", 64'(c_tmo), 64'd1);
    tick();
    check_val("to_busy_after", 64'(c_busy), 64'd0);
    check_val("to_flag_sticky", 64'(c_tmo), 64'd1);
    start_sweep(2, 6'd3, 6'd2);
    check_val("to_cleared_on_start", 64'(c_tmo), 64'd0);
    repeat (2) tick();
    check_val("to_no_stream", 64'(valid_c), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fib_sweeper.md
FIB_SWEEPER -- requirements
Module: fib_sweeper

Interface
REQ-001 Parameters SHALL be: INPUT_WIDTH, 6, width of n; OUTPUT_WIDTH, 32, width of result; TIMEOUT_CYCLES, 1024, maximum wait per calculator request.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  begin sweep; sampled only in IDLE.
REQ-006 n_first, n_last  in  INPUT_WIDTH  inclusive sweep range, latched at start.
REQ-007 busy  out  1  high in every state except IDLE.
REQ-008 done  out  1  one-cycle pulse at sweep end.
REQ-009 timeout  out  1  sticky; set on calculator timeout, cleared at next accepted start.
REQ-010 sweep_overflow  out  1  sticky OR of all captured overflow flags; cleared at accepted start.
REQ-011 fib_go  out  1; fib_n  out  INPUT_WIDTH; fib_result  in  OUTPUT_WIDTH; fib_overflow  in  1; fib_done  in  1  calculator initiator port.
REQ-012 out_valid  out  1; out_ready  in  1; out_n  out  INPUT_WIDTH; out_result  out  OUTPUT_WIDTH; out_overflow  out  1; out_last  out  1  result stream.

Function
REQ-013 The FSM SHALL have states IDLE, ISSUE, WAIT_CLEAR, WAIT_DONE, EMIT, FINISH.
REQ-014 IDLE: start=1 with n_first<=n_last SHALL go to ISSUE with cur_n=n_first; start=1 with n_first>n_last SHALL go to FINISH with no stream output.
REQ-015 ISSUE SHALL assert fib_go for exactly one cycle with fib_n=cur_n, then go to WAIT_CLEAR.
REQ-016 fib_n SHALL hold cur_n stable from ISSUE through EMIT.
REQ-017 WAIT_CLEAR SHALL wait for fib_done=0, then go to WAIT_DONE; a stale done from the previous request SHALL never be captured.
REQ-018 WAIT_DONE SHALL, on fib_done=1, register fib_result and fib_overflow into out_result/out_overflow, OR fib_overflow into sweep_overflow, and go to EMIT.
REQ-019 EMIT SHALL hold out_valid=1 with stable payload until out_ready=1.
REQ-020 On that handshake, EMIT SHALL go to FINISH if cur_n==n_last, else to ISSUE with cur_n+1.
REQ-021 out_last SHALL equal (cur_n==n_last) while out_valid=1.
REQ-022 cur_n SHALL never wrap: n_last=2^INPUT_WIDTH-1 SHALL terminate after that value.
REQ-023 fib_go SHALL stay 0 while out_valid=1 (no request issued during backpressure).
REQ-024 A wait counter SHALL reset on entry to WAIT_CLEAR and count in WAIT_CLEAR and WAIT_DONE.
REQ-025 When the wait counter reaches TIMEOUT_CYCLES, the block SHALL set timeout, drop the current n, and go to FINISH.
REQ-026 FINISH SHALL pulse done for one cycle and return to IDLE; busy=0 in that IDLE cycle.
REQ-027 start asserted while busy SHALL be ignored.
REQ-028 Stream values SHALL pass through unmodified; F(0)=0, F(1)=1, F(2)=1.

Reset
REQ-029 rst SHALL force IDLE with every output 0: busy, done, timeout, sweep_overflow, fib_go, fib_n, out_valid, out_n, out_result, out_overflow, out_last.
REQ-030 The wait counter and latched range SHALL also reset to 0.
REQ-031 rst mid-sweep SHALL abandon the sweep without emitting a partial beat.

Structure
REQ-032 A shared package fib_pkg SHALL hold the sweeper state typedef and the TIMEOUT_CYCLES default.
REQ-033 The calculator SHALL be external; the bench SHALL instantiate fib as the responder.
REQ-034 One sub-module, fib_wait_timer, SHALL implement the wait counter with clear, enable and expired.

Verification
REQ-035 Range: OUTPUT_WIDTH=32, n_first=0, n_last=10, out_ready=1 -> 11 beats 0,1,1,2,3,5,8,13,21,34,55; out_last only on n=10; one done pulse.
REQ-036 Overflow: OUTPUT_WIDTH=8, n 13..14 -> beat 233 with out_overflow=0; next beat with out_overflow=1; sweep_overflow=1 at done.
REQ-037 Empty range: n_first=5, n_last=3 -> no out_valid; done pulse within 3 cycles of start; timeout=0.
REQ-038 Backpressure: out_ready low 20 cycles on n=4 -> out_valid and payload 3 stable; fib_go=0 throughout; sweep resumes correctly.
REQ-039 Timeout: TIMEOUT_CYCLES=16, stub responder never asserts fib_done -> timeout=1 and done pulse within 20 cycles of fib_go; busy then 0.
REQ-040 Reset mid-sweep: rst during WAIT_DONE of n=6 -> all outputs 0 next cycle; a new sweep 2..3 yields exactly 1,2.
